// File: rtl/picorv32_pcpi_nanov_mulx_pkg.sv
// Shared constants and FSM state type for the nanoV multi-cycle multiplier.
package nanoV_mul_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/picorv32_pcpi_nanov_mulx_if.sv
// PCPI bus bundle: master is the core side, slave is the co-processor side.
interface picorv32_pcpi_nanov_mulx_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

endinterface

// File: rtl/picorv32_pcpi_nanov_mulx_step.sv
// Shift-add engine: retires STEP_BITS multiplier bits per step into a 64-bit
// accumulator. Optional NANOV_MUL_EARLY_EXIT_EN flags the last step as soon
// as the remaining multiplier bits are all zero.
module nanoV_mul_step #(
    parameter int unsigned RS2_WIDTH = 16,
    parameter int unsigned STEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load,
    input  logic                 step,
    input  logic [31:0]          mcand_in,
    input  logic [RS2_WIDTH-1:0] mplier_in,
    output logic [63:0]          acc_next,
    output logic                 done
);

    localparam int unsigned STEPS = RS2_WIDTH / STEP_BITS;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    logic [63:0]          acc;
    logic [63:0]          mcand;
    logic [RS2_WIDTH-1:0] mplier;
    logic [RS2_WIDTH-1:0] mplier_next;
    logic [CNT_W-1:0]     cnt;
    logic [63:0]          partial;

    // Partial product of the low multiplier digit; mcand is pre-shifted so no extra alignment is needed.
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < STEP_BITS; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
        acc_next    = acc + partial;
        mplier_next = mplier >> STEP_BITS;
        done        = (cnt == CNT_W'(1));
`ifdef NANOV_MUL_EARLY_EXIT_EN
        if (mplier_next == '0) begin
            done = 1'b1;
        end
`endif
    end

    // Operand/accumulator registers: load clears, step accumulates and shifts.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {32'd0, mcand_in};
            mplier <= mplier_in;
            cnt    <= CNT_W'(STEPS);
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << STEP_BITS;
            mplier <= mplier_next;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/picorv32_pcpi_nanov_mulx.sv
// Multi-cycle M-extension multiplier on the PicoRV32 PCPI bus.
// RS2_WIDTH=16 claims MUL only; RS2_WIDTH=32 adds MULH/MULHSU/MULHU.
// Optional macro NANOV_MUL_EARLY_EXIT_EN enables variable-latency early exit.
module picorv32_pcpi_nanov_mulx
    import nanoV_mul_pkg::*;
#(
    parameter int unsigned RS2_WIDTH = 16,
    parameter int unsigned STEP_BITS = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    picorv32_pcpi_nanov_mulx_if.slave     bus
);

    state_t      state, state_next;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [31:0] rd_q;

    logic [2:0]  funct3;
    logic        claim;
    logic        rs1_signed, rs2_signed;
    logic [31:0] rs1_mag, rs2_mag;
    logic        neg_in;
    logic        load, step, done;
    logic [63:0] acc_next;
    logic [63:0] product;
    logic [31:0] result;
    logic        unused_ok;

    assign funct3    = bus.pcpi_insn[14:12];
    assign unused_ok = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7], rs2_mag};

    // Decode and operand magnitude/sign preparation for the accepting cycle.
    always_comb begin
        claim = 1'b0;
        if (bus.pcpi_insn[6:0] == OPCODE_OP && bus.pcpi_insn[31:25] == FUNCT7_MULDIV) begin
            if (funct3 == F3_MUL) begin
                claim = 1'b1;
            end else if (RS2_WIDTH == 32 &&
                         (funct3 == F3_MULH || funct3 == F3_MULHSU || funct3 == F3_MULHU)) begin
                claim = 1'b1;
            end
        end
        rs1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
        rs2_signed = (RS2_WIDTH == 32) && (funct3 == F3_MULH);
        rs1_mag    = (rs1_signed && bus.pcpi_rs1[31]) ? (~bus.pcpi_rs1 + 32'd1) : bus.pcpi_rs1;
        rs2_mag    = (rs2_signed && bus.pcpi_rs2[31]) ? (~bus.pcpi_rs2 + 32'd1) : bus.pcpi_rs2;
        neg_in     = (rs1_signed && bus.pcpi_rs1[31]) ^ (rs2_signed && bus.pcpi_rs2[31]);
    end

    nanoV_mul_step #(
        .RS2_WIDTH (RS2_WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .step      (step),
        .mcand_in  (rs1_mag),
        .mplier_in (rs2_mag[RS2_WIDTH-1:0]),
        .acc_next  (acc_next),
        .done      (done)
    );

    // Final sign fix-up and half select, taken from the accumulator value of the last step.
    always_comb begin
        product = neg_q ? (~acc_next + 64'd1) : acc_next;
        result  = (op_q == F3_MUL) ? product[31:0] : product[63:32];
    end

    // Next-state and engine control.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pcpi_valid && claim) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!bus.pcpi_valid) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (done) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched op/sign, and registered result (captured on the final step).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            op_q  <= F3_MUL;
            neg_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                op_q  <= funct3;
                neg_q <= neg_in;
            end
            if (step && done) begin
                rd_q <= result;
            end
        end
    end

    assign bus.pcpi_wait  = (state == BUSY);
    assign bus.pcpi_ready = (state == DONE);
    assign bus.pcpi_wr    = (state == DONE);
    assign bus.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_picorv32_pcpi_nanov_mulx.sv
// Table-driven bench for picorv32_pcpi_nanov_mulx at RS2_WIDTH 16 and 32.
// Honours NANOV_MUL_EARLY_EXIT_EN when choosing expected latencies.
module tb_picorv32_pcpi_nanov_mulx;
    import nanoV_mul_pkg::*;

`ifdef NANOV_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;

    picorv32_pcpi_nanov_mulx_if bus16 ();
    picorv32_pcpi_nanov_mulx_if bus32 ();

    picorv32_pcpi_nanov_mulx #(.RS2_WIDTH(16), .STEP_BITS(4)) dut16 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus16.slave)
    );

    picorv32_pcpi_nanov_mulx #(.RS2_WIDTH(32), .STEP_BITS(4)) dut32 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus32.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sel;       // 0: RS2_WIDTH=16 instance, 1: RS2_WIDTH=32 instance
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          claim;
        logic [31:0] rd;
        int          lat;
        int          lat_early;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, OPCODE_OP};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [31:0] insn,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        if (sel) begin
            bus32.pcpi_valid = v; bus32.pcpi_insn = insn;
            bus32.pcpi_rs1 = rs1; bus32.pcpi_rs2 = rs2;
        end else begin
            bus16.pcpi_valid = v; bus16.pcpi_insn = insn;
            bus16.pcpi_rs1 = rs1; bus16.pcpi_rs2 = rs2;
        end
    endtask

    task automatic sample(input bit sel, output logic w, output logic r,
                          output logic wr, output logic [31:0] rd);
        if (sel) begin
            w = bus32.pcpi_wait; r = bus32.pcpi_ready; wr = bus32.pcpi_wr; rd = bus32.pcpi_rd;
        end else begin
            w = bus16.pcpi_wait; r = bus16.pcpi_ready; wr = bus16.pcpi_wr; rd = bus16.pcpi_rd;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic w, r, wr;
        logic [31:0] rd;
        int n;
        bit got, seen, wait_ok;
        int lat_exp;
        lat_exp = EARLY ? v.lat_early : v.lat;
        @(negedge clk);
        drive(v.sel, 1'b1, v.insn, v.rs1, v.rs2);
        if (!v.claim) begin
            seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                sample(v.sel, w, r, wr, rd);
                if (w || r || wr) seen = 1'b1;
            end
            check({v.name, "_unclaimed"}, 64'(seen), 64'd0);
            drive(v.sel, 1'b0, 32'd0, 32'd0, 32'd0);
        end else begin
            n = 0; got = 1'b0; wait_ok = 1'b1;
            w = 1'b0; r = 1'b0; wr = 1'b0; rd = '0;
            while (n < 40 && !got) begin
                @(negedge clk);
                n++;
                sample(v.sel, w, r, wr, rd);
                if (r) got = 1'b1;
                else if (!w) wait_ok = 1'b0;
            end
            check({v.name, "_ready_seen"}, 64'(got), 64'd1);
            if (got) begin
                check({v.name, "_latency"}, 64'(n), 64'(lat_exp));
                check({v.name, "_rd"}, 64'(rd), 64'(v.rd));
                check({v.name, "_wr"}, 64'(wr), 64'd1);
                check({v.name, "_wait_at_ready"}, 64'(w), 64'd0);
                check({v.name, "_wait_while_busy"}, 64'(wait_ok), 64'd1);
            end
            drive(v.sel, 1'b0, 32'd0, 32'd0, 32'd0);
            @(negedge clk);
            sample(v.sel, w, r, wr, rd);
            check({v.name, "_ready_one_cycle"}, 64'(r), 64'd0);
            check({v.name, "_rd_held"}, 64'(rd), 64'(v.rd));
        end
    endtask

    // Abort in the 2nd BUSY cycle, via reset or by dropping pcpi_valid.
    task automatic abort_seq(input string name, input bit sel, input bit use_reset);
        logic w, r, wr;
        logic [31:0] rd;
        bit seen;
        @(negedge clk);
        drive(sel, 1'b1, enc(FUNCT7_MULDIV, F3_MUL), 32'h12345678, 32'h0000FFFF);
        @(negedge clk);
        sample(sel, w, r, wr, rd);
        check({name, "_busy1"}, 64'(w), 64'd1);
        @(negedge clk);
        sample(sel, w, r, wr, rd);
        check({name, "_busy2"}, 64'(w), 64'd1);
        if (use_reset) resetn = 1'b0;
        drive(sel, 1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        sample(sel, w, r, wr, rd);
        check({name, "_idle_wait"}, 64'(w), 64'd0);
        check({name, "_idle_ready"}, 64'(r), 64'd0);
        if (use_reset) check({name, "_rd_cleared"}, 64'(rd), 64'd0);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            sample(sel, w, r, wr, rd);
            if (r || wr || w) seen = 1'b1;
        end
        check({name, "_no_ready_pulse"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic w, r, wr;
        logic [31:0] rd;
        vec_t m76;

        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 32'd0);

        //         name          sel   insn                             rs1           rs2           claim rd            lat early
        tbl.push_back('{"mul16_a",   1'b0, enc(FUNCT7_MULDIV, F3_MUL),    32'h12345678, 32'hFFFF0002, 1'b1, 32'h2468ACF0, 5, 2});
        tbl.push_back('{"mul16_7x6", 1'b0, enc(FUNCT7_MULDIV, F3_MUL),    32'd7,        32'd6,        1'b1, 32'd42,       5, 2});
        tbl.push_back('{"mul16_max", 1'b0, enc(FUNCT7_MULDIV, F3_MUL),    32'hFFFFFFFF, 32'h0000FFFF, 1'b1, 32'hFFFF0001, 5, 5});
        tbl.push_back('{"mul16_hi",  1'b0, enc(FUNCT7_MULDIV, F3_MUL),    32'h12345678, 32'h00050000, 1'b1, 32'h00000000, 5, 2});
        tbl.push_back('{"mul32_x3",  1'b1, enc(FUNCT7_MULDIV, F3_MUL),    32'h12345678, 32'h00000003, 1'b1, 32'h369D0368, 9, 2});
        tbl.push_back('{"mulhu_max", 1'b1, enc(FUNCT7_MULDIV, F3_MULHU),  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 9, 9});
        tbl.push_back('{"mulh_m1",   1'b1, enc(FUNCT7_MULDIV, F3_MULH),   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 9, 2});
        tbl.push_back('{"mulh_min",  1'b1, enc(FUNCT7_MULDIV, F3_MULH),   32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 9, 9});
        tbl.push_back('{"mulhsu_a",  1'b1, enc(FUNCT7_MULDIV, F3_MULHSU), 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'hFFFFFFFF, 9, 2});
        tbl.push_back('{"mulhsu_b",  1'b1, enc(FUNCT7_MULDIV, F3_MULHSU), 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 9, 9});
        tbl.push_back('{"mulh_mix",  1'b1, enc(FUNCT7_MULDIV, F3_MULH),   32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 9, 9});
        tbl.push_back('{"mul32_x1",  1'b1, enc(FUNCT7_MULDIV, F3_MUL),    32'hDEADBEEF, 32'h00000001, 1'b1, 32'hDEADBEEF, 9, 2});
        tbl.push_back('{"mul32_b16", 1'b1, enc(FUNCT7_MULDIV, F3_MUL),    32'h12345678, 32'h00010000, 1'b1, 32'h56780000, 9, 6});
        tbl.push_back('{"mulhu_x0",  1'b1, enc(FUNCT7_MULDIV, F3_MULHU),  32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 9, 2});
        tbl.push_back('{"mul32_neg", 1'b1, enc(FUNCT7_MULDIV, F3_MUL),    32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFF1, 9, 2});
        tbl.push_back('{"add16",     1'b0, enc(7'b0000000, F3_MUL),       32'd3,        32'd4,        1'b0, 32'd0,        0, 0});
        tbl.push_back('{"mulh16",    1'b0, enc(FUNCT7_MULDIV, F3_MULH),   32'd3,        32'd4,        1'b0, 32'd0,        0, 0});
        tbl.push_back('{"mulhu16",   1'b0, enc(FUNCT7_MULDIV, F3_MULHU),  32'd3,        32'd4,        1'b0, 32'd0,        0, 0});
        tbl.push_back('{"div32",     1'b1, enc(FUNCT7_MULDIV, 3'b100),    32'd3,        32'd4,        1'b0, 32'd0,        0, 0});
        tbl.push_back('{"add32",     1'b1, enc(7'b0000000, F3_MUL),       32'd3,        32'd4,        1'b0, 32'd0,        0, 0});

        m76 = '{"mul32_7x6", 1'b1, enc(FUNCT7_MULDIV, F3_MUL), 32'd7, 32'd6, 1'b1, 32'd42, 9, 2};

        repeat (3) @(negedge clk);
        sample(1'b0, w, r, wr, rd);
        check("reset16_outputs", {61'd0, w, r, wr}, 64'd0);
        check("reset16_rd", 64'(rd), 64'd0);
        sample(1'b1, w, r, wr, rd);
        check("reset32_outputs", {61'd0, w, r, wr}, 64'd0);
        check("reset32_rd", 64'(rd), 64'd0);
        resetn = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        abort_seq("abort_reset32", 1'b1, 1'b1);
        run_vec(m76);
        abort_seq("abort_valid32", 1'b1, 1'b0);
        run_vec(m76);
        abort_seq("abort_valid16", 1'b0, 1'b0);
        run_vec(tbl[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/picorv32_pcpi_nanov_mulx.md
Name: picorv32_pcpi_nanoV_mulx

Overview:
- Parametrised, multi-cycle M-extension multiply co-processor on the PicoRV32 PCPI bus.
- Successor to the single-cycle 32x16 MUL unit.
- Uses a configurable rs2 width and a shift-add engine that consumes STEP_BITS multiplier bits per cycle, trading latency for LUTs.
- With RS2_WIDTH=32 it also executes MULH, MULHSU and MULHU.

Parameters:
- RS2_WIDTH, 16: rs2 bits used; legal values 16 or 32. At 16 only MUL is claimed and rs2[31:16] is ignored.
- STEP_BITS, 4: multiplier bits retired per BUSY cycle. Legal values 1, 2, 4, 8; must divide RS2_WIDTH.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- pcpi_valid  in  1  core presents instruction; held until pcpi_ready
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  write rd; equals pcpi_ready
- pcpi_rd  out  32  result
- pcpi_wait  out  1  instruction claimed, result pending
- pcpi_ready  out  1  one-cycle result strobe

Behaviour:
- **Reset.** One clock; resetn is synchronous and active-low. On reset: state=IDLE; pcpi_wr, pcpi_ready, pcpi_wait=0; pcpi_rd=0. Reset mid-operation aborts with no ready pulse.
- **Decode.** Claim when opcode==0110011, funct7==0000001 and funct3 is one of:
  - 000 MUL (always).
  - 001 MULH, 010 MULHSU, 011 MULHU (only when RS2_WIDTH=32).
  - Anything else is never claimed; wait and ready stay 0, so the core traps.
- **FSM: IDLE -> BUSY -> DONE -> IDLE.**
- **IDLE.** On a claimed insn:
  - Latch the op.
  - Compute operand magnitudes:
    - rs1 is signed for MULH and MULHSU.
    - rs2 is signed for MULH only (RS2_WIDTH=32).
    - MUL is sign-agnostic and uses raw bits.
  - Latch neg = XOR of the signs of the signed operands.
  - Clear the 64-bit accumulator, set the step counter to RS2_WIDTH/STEP_BITS, go to BUSY.
  - pcpi_wait=1 from the cycle after acceptance.
- **BUSY.** Each cycle:
  - acc += mcand * mplier[STEP_BITS-1:0], shifted into position.
  - Shift mplier right by STEP_BITS; decrement the counter.
  - When the counter reaches 0, go to DONE.
  - pcpi_wait=1 throughout.
- **DONE.** One cycle:
  - pcpi_ready=pcpi_wr=1, pcpi_wait=0.
  - pcpi_rd = MUL: low 32 bits of the product; MULH*/MULHU: high 32 bits. The product is negated (two's complement, 64-bit) when neg=1.
  - pcpi_rd is registered and holds its value until the next DONE.
  - Unconditionally return to IDLE.
- **Latency.** Ready asserts exactly 1 + RS2_WIDTH/STEP_BITS cycles after the accepting edge: 5 cycles at the defaults, 9 at 32/4.
- **Back-to-back.** A new instruction is accepted only in IDLE. The cycle after DONE is always IDLE, so a stale pcpi_valid in the ready cycle never re-triggers.
- **Abort.** pcpi_valid dropping while BUSY aborts to IDLE with no ready pulse.
- **Widths.** mcand is 32 bits (64 in the datapath); the accumulator is 64 bits. Overflow beyond 64 bits is impossible by construction.

Optional Feature:
- Macro: NANOV_MUL_EARLY_EXIT_EN.
- Defined: BUSY exits to DONE as soon as the remaining mplier bits are all zero, checked after each step. Latency becomes variable, between 2 cycles and the maximum; a multiplier of 0 gives ready 2 cycles after acceptance.
- Undefined: latency is fixed as above, and there is no zero-detect logic.

Decomposition:
- Package nanoV_mul_pkg holds:
  - OPCODE_OP=7'b0110011, FUNCT7_MULDIV=7'b0000001.
  - funct3 constants F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU.
  - State encoding IDLE, BUSY, DONE.
- One sub-module is natural: nanoV_mul_step, holding the accumulator, mplier shift register and step counter. It has load, step and done ports. The top level keeps the PCPI decode, FSM and sign/negate logic.

Test Plan:
1. RS2_WIDTH=16, MUL rs1=0x12345678, rs2=0xFFFF0002 -> rd=0x2468ACF0, ready 5 cycles after accept, wait high for the 4 cycles between.
2. RS2_WIDTH=32, MUL rs1=0x12345678, rs2=0x00000003 -> rd=0x369D0368; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rd=0xFFFFFFFE.
3. RS2_WIDTH=32:
   - MULH -1 x -1 -> rd=0x00000000.
   - MULH 0x80000000 x 0x80000000 -> rd=0x40000000.
   - MULHSU 0xFFFFFFFF x 0x00000002 -> rd=0xFFFFFFFF.
4. Unclaimed insns (funct7=0000000 ADD, or RS2_WIDTH=16 with MULH, or DIV funct3=100) -> wait and ready stay 0 for 20 cycles.
5. Reset asserted, and separately pcpi_valid deasserted, in the 2nd BUSY cycle -> no ready pulse, IDLE next cycle. A following MUL 7x6 -> rd=42.
6. With NANOV_MUL_EARLY_EXIT_EN and RS2_WIDTH=32: MUL x 0x00000001 -> ready 2 cycles after accept. Without the macro -> ready 9 cycles after accept, same rd.
